// File: rtl/user_app_pkg.sv
// Shared definitions for the user_app block-copy engine: register map, GTP idle
// pattern, FIFO geometry and small data helpers.
package user_app_pkg;

  localparam int unsigned R_STATUS = 0;
  localparam int unsigned R_CMD    = 1;
  localparam int unsigned R_SRC    = 2;
  localparam int unsigned R_DST    = 3;
  localparam int unsigned R_LEN    = 4;
  localparam int unsigned R_CSUM   = 5;

  localparam logic [15:0] GTP_IDLE_TXD = 16'h50BC;
  localparam logic [1:0]  GTP_IDLE_TXK = 2'b01;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = 2;
  localparam int unsigned FIFO_CNT_W = 3;

  typedef struct packed {
    logic [31:0] words;
    logic [19:0] rsvd1;
    logic [3:0]  aligned;
    logic [4:0]  rsvd0;
    logic        gtp_rdy;
    logic        busy;
    logic        done;
  } status_t;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_dat,
                                             input logic [63:0] wr_dat,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_dat;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = wr_dat[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [63:0] fold128(input logic [127:0] word);
    return word[127:64] ^ word[63:0];
  endfunction

endpackage

// File: rtl/user_app_fifo.sv
// 4-entry synchronous FIFO with occupancy count; head is visible combinationally.
// Pushes into a full FIFO and pops from an empty one are dropped.
module user_app_fifo
  import user_app_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_vld_i,
  input  logic [WIDTH-1:0]      push_dat_i,
  input  logic                  pop_rdy_i,
  output logic [WIDTH-1:0]      head_dat_o,
  output logic                  empty_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNT_W-1:0] cnt_q;
  logic                  push, pop;

  assign push = push_vld_i && (cnt_q != FIFO_CNT_W'(FIFO_DEPTH));
  assign pop  = pop_rdy_i && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      cnt_q <= cnt_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;

endmodule

// File: rtl/user_app.sv
// Register-programmed copy engine: bank 0 reads -> 4-entry FIFO -> bank 1 writes; GTP lanes send idle.
// Reads are throttled so in-flight reads plus FIFO occupancy never exceed 4; USER_APP_CHECKSUM_EN adds an R5 checksum.
module user_app
  import user_app_pkg::*;
#(
  parameter int NUM_GTP       = 4,
  parameter int NUM_BANK      = 6,
  parameter int DATA_WIDTH    = 128,
  parameter int TAG_WIDTH     = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BE_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clk2x,
  input  logic [63:0]                       reg_in,
  input  logic [255:0]                      reg_wr,
  output logic [2047:0]                     reg_out,
  input  logic                              gtp_clk,
  input  logic                              gtp_rdy,
  output logic [16*NUM_GTP-1:0]             gtp_txd,
  output logic [2*NUM_GTP-1:0]              gtp_txk,
  input  logic [16*NUM_GTP-1:0]             gtp_rxd,
  input  logic [2*NUM_GTP-1:0]              gtp_rxk,
  input  logic [NUM_GTP-1:0]                gtp_aligned,
  input  logic [NUM_BANK-1:0]               valid,
  input  logic [NUM_BANK*DATA_WIDTH-1:0]    q,
  input  logic [NUM_BANK*TAG_WIDTH-1:0]     qtag,
  input  logic [NUM_BANK-1:0]               ready,
  output logic [NUM_BANK-1:0]               req,
  output logic [NUM_BANK-1:0]               ce,
  output logic [NUM_BANK-1:0]               w,
  output logic [NUM_BANK*ADDRESS_WIDTH-1:0] a,
  output logic [NUM_BANK*TAG_WIDTH-1:0]     tag,
  output logic [NUM_BANK*DATA_WIDTH-1:0]    d,
  output logic [NUM_BANK*BE_WIDTH-1:0]      be
);

  logic [63:0]              src_reg_q, dst_reg_q, len_reg_q;
  logic                     gtp_rdy_q;
  logic [NUM_GTP-1:0]       aligned_q;
  logic [ADDRESS_WIDTH-1:0] src_q, dst_q;
  logic [31:0]              len_q;
  logic [31:0]              rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [2:0]               infl_q, infl_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     start_acc, rd_req, rd_acc, rsp_vld, wr_req, wr_acc;
  logic [DATA_WIDTH-1:0]    fifo_head;
  logic                     fifo_empty;
  logic [FIFO_CNT_W-1:0]    fifo_cnt;
  logic [63:0]              csum_rd;
  status_t                  status;

  assign start_acc = reg_wr[8*R_CMD] && reg_in[0] && !busy_q;

  // Credit check: reads in flight plus queued words may not exceed the FIFO depth.
  assign rd_req  = busy_q && (rd_cnt_q != len_q)
                   && (({1'b0, infl_q} + {1'b0, fifo_cnt}) < 4'(FIFO_DEPTH));
  assign rd_acc  = rd_req && ready[0];
  // Responses with nothing outstanding are stale (issued before a reset) and dropped.
  assign rsp_vld = valid[0] && busy_q && (infl_q != 3'd0);
  assign wr_req  = busy_q && !fifo_empty;
  assign wr_acc  = wr_req && ready[1];

  user_app_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (rsp_vld),
    .push_dat_i (q[0 +: DATA_WIDTH]),
    .pop_rdy_i  (wr_acc),
    .head_dat_o (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    busy_d   = busy_q;
    done_d   = done_q;
    rd_cnt_d = rd_cnt_q + 32'(rd_acc);
    wr_cnt_d = wr_cnt_q + 32'(wr_acc);
    infl_d   = infl_q + 3'(rd_acc) - 3'(rsp_vld);
    if (start_acc) begin
      busy_d   = (len_reg_q[31:0] != 32'd0);
      done_d   = (len_reg_q[31:0] == 32'd0);
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      infl_d   = '0;
    end else if (busy_q && (wr_cnt_q == len_q)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg_q <= '0;
      dst_reg_q <= '0;
      len_reg_q <= '0;
      gtp_rdy_q <= 1'b0;
      aligned_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      infl_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      src_reg_q <= byte_merge(src_reg_q, reg_in, reg_wr[8*R_SRC +: 8]);
      dst_reg_q <= byte_merge(dst_reg_q, reg_in, reg_wr[8*R_DST +: 8]);
      len_reg_q <= byte_merge(len_reg_q, reg_in, reg_wr[8*R_LEN +: 8]);
      gtp_rdy_q <= gtp_rdy;
      aligned_q <= gtp_aligned;
      if (start_acc) begin
        src_q <= src_reg_q[ADDRESS_WIDTH-1:0];
        dst_q <= dst_reg_q[ADDRESS_WIDTH-1:0];
        len_q <= len_reg_q[31:0];
      end
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      infl_q   <= infl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef USER_APP_CHECKSUM_EN
  logic [63:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) csum_q <= '0;
    else if (wr_acc)      csum_q <= csum_q ^ fold128(fifo_head);
  end

  assign csum_rd = csum_q;
`else
  assign csum_rd = '0;
`endif

  always_comb begin
    status         = '0;
    status.done    = done_q;
    status.busy    = busy_q;
    status.gtp_rdy = gtp_rdy_q;
    status.aligned = aligned_q;
    status.words   = wr_cnt_q;
    reg_out                   = '0;
    reg_out[64*R_STATUS +: 64] = status;
    reg_out[64*R_SRC +: 64]    = src_reg_q;
    reg_out[64*R_DST +: 64]    = dst_reg_q;
    reg_out[64*R_LEN +: 64]    = len_reg_q;
    reg_out[64*R_CSUM +: 64]   = csum_rd;
  end

  // Every request field is zero whenever its req is low.
  always_comb begin
    req = '0;
    ce  = '0;
    w   = '0;
    a   = '0;
    tag = '0;
    d   = '0;
    be  = '0;
    req[0] = rd_req;
    ce[0]  = rd_req;
    if (rd_req) begin
      a[0 +: ADDRESS_WIDTH] = src_q + ADDRESS_WIDTH'(rd_cnt_q);
      tag[0 +: TAG_WIDTH]   = TAG_WIDTH'(rd_cnt_q[1:0]);
    end
    req[1] = wr_req;
    ce[1]  = wr_req;
    w[1]   = wr_req;
    if (wr_req) begin
      a[ADDRESS_WIDTH +: ADDRESS_WIDTH] = dst_q + ADDRESS_WIDTH'(wr_cnt_q);
      d[DATA_WIDTH +: DATA_WIDTH]       = fifo_head;
      be[BE_WIDTH +: BE_WIDTH]          = {BE_WIDTH{1'b1}};
    end
  end

  assign gtp_txd = {NUM_GTP{GTP_IDLE_TXD}};
  assign gtp_txk = {NUM_GTP{GTP_IDLE_TXK}};

  logic unused_ok;
  assign unused_ok = ^{clk2x, gtp_clk, gtp_rxd, gtp_rxk, qtag,
                       valid[NUM_BANK-1:1], q[NUM_BANK*DATA_WIDTH-1:DATA_WIDTH],
                       ready[NUM_BANK-1:2], reg_wr[255:40], reg_wr[15:9], reg_wr[7:0]};

endmodule

// File: tb/tb_user_app.sv
// Scoreboard bench for user_app: bank models on the falling edge, expected writes queued at start.
module tb_user_app;
  import user_app_pkg::*;

  logic          clk = 1'b0, clk2x = 1'b0, rst;
  logic [63:0]   reg_in;
  logic [255:0]  reg_wr;
  logic [2047:0] reg_out;
  logic          gtp_clk, gtp_rdy;
  logic [63:0]   gtp_txd, gtp_rxd;
  logic [7:0]    gtp_txk, gtp_rxk;
  logic [3:0]    gtp_aligned;
  logic [5:0]    valid, ready, req, ce, w;
  logic [767:0]  q, d;
  logic [11:0]   qtag, tag;
  logic [191:0]  a;
  logic [95:0]   be;

  always #10 clk = ~clk;
  always #5 clk2x = ~clk2x;
  assign gtp_clk = clk;

  user_app dut (
    .clk(clk), .rst(rst), .clk2x(clk2x), .reg_in(reg_in), .reg_wr(reg_wr), .reg_out(reg_out),
    .gtp_clk(gtp_clk), .gtp_rdy(gtp_rdy), .gtp_txd(gtp_txd), .gtp_txk(gtp_txk),
    .gtp_rxd(gtp_rxd), .gtp_rxk(gtp_rxk), .gtp_aligned(gtp_aligned),
    .valid(valid), .q(q), .qtag(qtag), .ready(ready),
    .req(req), .ce(ce), .w(w), .a(a), .tag(tag), .d(d), .be(be)
  );

  typedef struct { logic [31:0] addr; logic [127:0] data; } wr_exp_t;
  typedef struct { logic [127:0] data; int due; } rsp_t;

  wr_exp_t      exp_q[$];
  rsp_t         rsp_q[$];
  logic [127:0] mem0[256];
  logic [127:0] mem1[256];
  logic [31:0]  rd_addr_exp;
  int           rd_idx, cyc, outstanding, max_out, hold1;
  int           n_checks = 0, n_errors = 0;
  logic [63:0]  csum_m;
  bit           any_req;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] fold(input logic [127:0] x);
    return x[127:64] ^ x[63:0];
  endfunction

  // Bank models: drive ready/valid at the falling edge, then record what the next rising edge accepts.
  initial begin
    rsp_t    r;
    wr_exp_t e;
    int      last_due;
    valid = '0; q = '0; qtag = '0; ready = '0;
    cyc = 0; outstanding = 0; max_out = 0; hold1 = 0; last_due = 0;
    forever begin
      @(negedge clk);
      cyc++;
      ready[0] = ($urandom_range(0, 3) != 0);
      if (hold1 > 0) begin
        ready[1] = 1'b0;
        hold1--;
      end else begin
        ready[1] = ($urandom_range(0, 4) != 0);
      end
      valid[0] = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        valid[0] = 1'b1;
        q[127:0] = r.data;
      end
      #1;
      if (rst) begin
        outstanding = 0;
      end else begin
        if (|req) any_req = 1'b1;
        if (req[0] && ready[0]) begin
          chk("rd_addr", a[31:0], rd_addr_exp);
          chk("rd_tag", tag[1:0], rd_idx[1:0]);
          chk("rd_w_be", {w[0], be[15:0]}, 17'd0);
          last_due = (cyc + $urandom_range(1, 3) > last_due) ? cyc + $urandom_range(1, 3) : last_due;
          rsp_q.push_back('{mem0[a[7:0]], last_due});
          rd_addr_exp++;
          rd_idx++;
          outstanding++;
        end
        if (req[1] && ready[1]) begin
          if (exp_q.size() == 0) begin
            chk("wr_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", a[63:32], e.addr);
            chk("wr_data", d[255:128], e.data);
            chk("wr_fields", {w[1], ce[1], be[31:16], tag[3:2]}, {2'b11, 16'hFFFF, 2'b00});
          end
          mem1[a[39:32]] = d[255:128];
          outstanding--;
        end
        if (outstanding > max_out) max_out = outstanding;
      end
    end
  end

  task automatic reg_write(input int idx, input logic [63:0] val, input logic [7:0] strb);
    logic [255:0] s;
    s = '0;
    s[8*idx +: 8] = strb;
    @(negedge clk);
    reg_in = val;
    reg_wr = s;
    @(negedge clk);
    reg_wr = '0;
  endtask

  task automatic pulse_start();
    reg_write(R_CMD, 64'h1, 8'h01);
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    reg_write(R_SRC, {32'h0, src}, 8'hFF);
    reg_write(R_DST, {32'h0, dst}, 8'hFF);
    reg_write(R_LEN, {32'h0, len}, 8'hFF);
    rd_addr_exp = src;
    rd_idx = 0;
    csum_m = '0;
    for (int k = 0; k < int'(len); k++) begin
      exp_q.push_back('{dst + k, mem0[8'(src + k)]});
      csum_m ^= fold(mem0[8'(src + k)]);
    end
    pulse_start();
    #2;
    if (len != 0) chk("start_to_req", req[0], 1'b1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (reg_out[0] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, reg_out[0], 1'b1);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_csum(input string name);
`ifdef USER_APP_CHECKSUM_EN
    chk(name, reg_out[64*R_CSUM +: 64], csum_m);
`else
    chk(name, reg_out[64*R_CSUM +: 64], 64'h0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reg_in = '0; reg_wr = '0; gtp_rdy = 1'b0; gtp_aligned = '0;
    gtp_rxd = '0; gtp_rxk = '0; any_req = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = {$urandom, $urandom, $urandom, $urandom};
      mem1[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_txd%0d", i), gtp_txd[16*i +: 16], 16'h50BC);
      chk($sformatf("rst_txk%0d", i), gtp_txk[2*i +: 2], 2'b01);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("reset_r0", reg_out[63:0], 64'h0);
    chk("reset_regout_any", |reg_out, 1'b0);
    chk("reset_req", {req, ce, w}, 18'h0);
    chk("reset_bus", |{a, tag, d, be}, 1'b0);

    gtp_rdy = 1'b1; gtp_aligned = 4'b1010;
    repeat (2) @(negedge clk);
    chk("status_gtp", reg_out[63:0], 64'h0000_0000_0000_0A04);

    reg_write(R_SRC, 64'h1122_3344_5566_7788, 8'hFF);
    chk("r2_full_write", reg_out[64*R_SRC +: 64], 64'h1122_3344_5566_7788);
    reg_write(R_SRC, 64'hFFFF_FFFF_FFFF_FFFF, 8'h02);
    chk("r2_byte_write", reg_out[64*R_SRC +: 64], 64'h1122_3344_5566_FF88);
    reg_write(6, 64'hDEAD_BEEF, 8'hFF);
    chk("r6_reads_zero", reg_out[64*6 +: 64], 64'h0);
    reg_write(R_CMD, 64'h2, 8'hFF);
    chk("r1_no_start", {reg_out[64*R_CMD +: 64], reg_out[1:0]}, 66'h0);

    for (int i = 0; i < 8; i++) mem0[i] = 128'(i);
    start_copy(0, 16, 8);
    wait_done("copy8", 300);
    for (int i = 0; i < 8; i++) chk($sformatf("copy8_mem%0d", 16 + i), mem1[16 + i], 128'(i));
    chk("copy8_r0", reg_out[63:0], 64'h0000_0008_0000_0A05);
    check_csum("copy8_csum");

    max_out = 0;
    start_copy(64, 128, 12);
    hold1 = 20;
    wait_done("bp", 400);
    for (int i = 0; i < 12; i++) chk($sformatf("bp_mem%0d", 128 + i), mem1[128 + i], mem0[64 + i]);
    chk("bp_max_outstanding", max_out, 4);

    start_copy(0, 200, 10);
    chk("busy_before_restart", reg_out[1], 1'b1);
    reg_write(R_LEN, 64'd50, 8'hFF);
    pulse_start();
    wait_done("restart", 400);
    chk("restart_words", reg_out[63:32], 32'd10);

    start_copy(0, 32, 20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    any_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_req", any_req, 1'b0);
    chk("abort_r0", reg_out[1:0], 2'b00);
    chk("abort_r2", reg_out[64*R_SRC +: 64], 64'h0);

    any_req = 1'b0;
    start_copy(5, 5, 0);
    chk("len0_done", reg_out[1:0], 2'b01);
    repeat (10) @(negedge clk);
    chk("len0_no_req", any_req, 1'b0);
    chk("len0_words", reg_out[63:32], 32'd0);

    mem0[40] = {4{32'h1111_1111}};
    mem0[41] = {4{32'h2222_2222}};
    start_copy(40, 48, 2);
    wait_done("csum_ab", 200);
    check_csum("csum_ab");

    start_copy(100, 150, 6);
    wait_done("csum_rand", 200);
    check_csum("csum_rand");
    chk("max_outstanding_final", max_out <= 4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
